mult_booth: RTL and testbench
=============================

// Module: mult_booth
// PURPOSE
//  Multicycle signed 32x32 multiplier using the radix-2 Booth algorithm, for the MIPS `mult` instruction.
//  Sits on the result side of the operand path.
//  - Takes operands from RegA/RegB.
//  - Delivers the 64-bit product to the HI/LO registers.
//  - Talks to the control FSM through a start/done handshake.
// PARAMETERS
//  WIDTH  32  operand width in bits; product is 2*WIDTH bits
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-low reset
//  MultCtrl   in   1        start request, sampled only in IDLE
//  A_in       in   WIDTH    multiplicand (two's complement)
//  B_in       in   WIDTH    multiplier (two's complement)
//  HI_out     out  WIDTH    upper half of product
//  LO_out     out  WIDTH    lower half of product
//  MultBusy   out  1        high whenever state != IDLE
//  MultDone   out  1        one-cycle pulse: HI_out/LO_out updated
// BEHAVIOUR
//  Reset and interface
//  - One clock; reset is asynchronous, active-low.
//  - reset=0 at any time, including mid-operation, immediately clears everything:
//    state=IDLE, HI_out=0, LO_out=0, MultDone=0, MultBusy=0, all internal registers 0.
//    The operation in flight is discarded.
//  Internal registers
//  - Acc: WIDTH+1 bits, sign-extended, so that M = -2^(WIDTH-1) is subtracted without overflow.
//  - Q: WIDTH bits. Q_1: 1 bit. M: WIDTH+1 bits, sign-extended A_in. Cnt: 6 bits.
//  FSM states: IDLE, RUN, DONE.
//  - IDLE: if MultCtrl=1 at edge E0, load M=sext(A_in), Acc=0, Q=B_in, Q_1=0, Cnt=0; go to RUN.
//    Otherwise stay in IDLE.
//  - RUN: one Booth step per edge, on {Q[0],Q_1}:
//    - 00 or 11: no add.
//    - 01: Acc = Acc + M.
//    - 10: Acc = Acc - M.
//    - Then arithmetic shift right of {Acc,Q,Q_1} by 1; Acc MSB is replicated.
//    - Cnt increments each step.
//    - The step at edge E0+WIDTH is the last: go to DONE.
//  - DONE: at edge E0+WIDTH+1: HI_out={Acc[WIDTH-1:0],Q}[2W-1:W], LO_out=Q, MultDone=1; go to IDLE.
//  - Edge E0+WIDTH+2: MultDone returns to 0.
//  Latency and handshake
//  - MultDone is high for exactly one cycle, WIDTH+1 edges after the start edge (33 for WIDTH=32).
//  - MultBusy is high from the edge after start through the DONE cycle, i.e. WIDTH+1 cycles.
//  - HI_out/LO_out are registered. They hold their value until the next MultDone and never show
//    partial products.
//  - MultCtrl while busy (RUN/DONE) is ignored, not queued. A_in/B_in may change freely after E0.
//  - MultCtrl=1 during the MultDone cycle (FSM already back in IDLE) is accepted as a new start.
//    There is no dead cycle between operations.
//  - MultCtrl held high continuously restarts on each return to IDLE.
//  Arithmetic
//  - Result is the exact signed 64-bit product for all operand pairs.
//  - No overflow flag; -2^31 * -2^31 = 2^62 is representable.
// TESTING
//  1. A=7, B=-3 (FFFFFFFD), pulse MultCtrl ->
//     MultDone exactly 33 cycles later; HI=FFFFFFFF, LO=FFFFFFEB.
//  2. A=B=80000000 ->
//     HI=40000000, LO=00000000 (checks the WIDTH+1-bit accumulator).
//  3. A=0000FFFF, B=0000FFFF ->
//     HI=00000000, LO=FFFE0001. Then A=0, B=12345678 -> HI=LO=0.
//  4. Start 5*6; pulse MultCtrl again with A=9, B=9 at cycle 10 ->
//     second request ignored; single MultDone with LO=0000001E; MultBusy high exactly 33 cycles.
//  5. Start 5*6; drop reset at cycle 15 ->
//     HI/LO/MultDone/MultBusy read 0 before the next edge. No MultDone after release until a new start.
//  6. Back-to-back: assert MultCtrl in the MultDone cycle with A=-1, B=-1 ->
//     first result held; second MultDone 33 cycles later with HI=0, LO=1.

Source files
------------

// File: rtl/mult_booth.sv
// -----------------------------------------------------------------------------
// mult_booth -- multicycle signed WIDTH x WIDTH radix-2 Booth multiplier used
// for the MIPS `mult` instruction. It takes operands from RegA/RegB and
// delivers the 2*WIDTH-bit product to the HI/LO registers, with a start/done
// handshake toward the control FSM.
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low reset
//   MultCtrl  in   1      start request, sampled only while idle
//   A_in      in   WIDTH  multiplicand (two's complement)
//   B_in      in   WIDTH  multiplier (two's complement)
//   HI_out    out  WIDTH  upper half of product (registered)
//   LO_out    out  WIDTH  lower half of product (registered)
//   MultBusy  out  1      high whenever the FSM is not idle
//   MultDone  out  1      one-cycle pulse when HI_out/LO_out are updated
//
// Timing: the start edge loads the operands, WIDTH edges perform one Booth
// step each, and the following edge publishes the product and pulses
// MultDone. The FSM is idle again during the MultDone cycle, so a new start
// can be accepted with no dead cycle.
// -----------------------------------------------------------------------------
module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out,
    output logic             MultBusy,
    output logic             MultDone
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           state_r;
    // Accumulator and multiplicand carry one extra sign bit so that
    // subtracting the most negative multiplicand cannot overflow.
    logic [WIDTH:0]   acc_r;
    logic [WIDTH:0]   m_r;
    logic [WIDTH-1:0] q_r;
    logic             q_1_r;
    logic [5:0]       cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH:0]   sum_s;

    // Booth recoding of the bit pair {Q[0], Q_1}: add, subtract or pass.
    function automatic logic [WIDTH:0] booth_sum(
        input logic [WIDTH:0] acc,
        input logic [WIDTH:0] m,
        input logic [1:0]     pair
    );
        case (pair)
            2'b01:   return acc + m;
            2'b10:   return acc - m;
            default: return acc;
        endcase
    endfunction

    // Partial sum for the current Booth step, before the arithmetic shift.
    always_comb begin
        sum_s = booth_sum(acc_r, m_r, {q_r[0], q_1_r});
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            acc_r   <= {(WIDTH+1){1'b0}};
            m_r     <= {(WIDTH+1){1'b0}};
            q_r     <= {WIDTH{1'b0}};
            q_1_r   <= 1'b0;
            cnt_r   <= 6'd0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (MultCtrl) begin
                        m_r     <= {A_in[WIDTH-1], A_in};
                        acc_r   <= {(WIDTH+1){1'b0}};
                        q_r     <= B_in;
                        q_1_r   <= 1'b0;
                        cnt_r   <= 6'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Arithmetic shift right of {Acc, Q, Q_1} by one.
                    acc_r  <= {sum_s[WIDTH], sum_s[WIDTH:1]};
                    q_r    <= {sum_s[0], q_r[WIDTH-1:1]};
                    q_1_r  <= q_r[0];
                    cnt_r  <= cnt_r + 6'd1;
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    if (cnt_r == LAST_STEP) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    hi_r    <= acc_r[WIDTH-1:0];
                    lo_r    <= q_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign HI_out   = hi_r;
    assign LO_out   = lo_r;
    assign MultBusy = busy_r;
    assign MultDone = done_r;

endmodule

// File: tb/tb_mult_booth.sv
// -----------------------------------------------------------------------------
// tb_mult_booth -- self-checking bench for mult_booth (WIDTH = 32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected products come from a plain 64-bit signed multiply.
// -----------------------------------------------------------------------------
module tb_mult_booth;

    logic        clk;
    logic        reset;
    logic        MultCtrl;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic        MultBusy;
    logic        MultDone;

    int n_cmp = 0;
    int n_err = 0;

    mult_booth #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MultCtrl (MultCtrl),
        .A_in     (A_in),
        .B_in     (B_in),
        .HI_out   (HI_out),
        .LO_out   (LO_out),
        .MultBusy (MultBusy),
        .MultDone (MultDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed product.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Observe from the falling edge after the start edge until MultDone.
    // lat = edges after the start edge; busy_n = sampled cycles with MultBusy.
    task automatic wait_done(output int lat, output int busy_n, output bit to);
        lat = 0; busy_n = 0; to = 1'b0;
        while (MultDone !== 1'b1) begin
            if (MultBusy === 1'b1) busy_n++;
            if (lat >= 100) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // Start one operation and wait for its completion; operands are
    // scrambled after the start edge since they may change freely.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n, output bit to);
        @(negedge clk);
        A_in = a; B_in = b; MultCtrl = 1'b1;
        @(negedge clk);
        MultCtrl = 1'b0; A_in = $urandom; B_in = $urandom;
        wait_done(lat, busy_n, to);
    endtask

    task automatic test_reset;
        reset = 1'b0; MultCtrl = 1'b0; A_in = 32'd0; B_in = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({HI_out, LO_out, MultBusy, MultDone} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_state: got HI=%h LO=%h busy=%b done=%b, want all 0",
                     HI_out, LO_out, MultBusy, MultDone);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] ta [5] = '{32'd7, 32'h80000000, 32'h0000FFFF, 32'd0, 32'hFFFFFFFF};
        logic [31:0] tb [5] = '{32'hFFFFFFFD, 32'h80000000, 32'h0000FFFF, 32'h12345678, 32'h7FFFFFFF};
        logic [63:0] exp [5] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000,
                                 64'h00000000_FFFE0001, 64'h0, 64'hFFFFFFFF_80000001};
        int lat, busy_n;
        bit to;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], lat, busy_n, to);
            n_cmp++;
            if (to || lat != 33) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: got %0d (timeout=%b), want 33", i, lat, to);
            end
            n_cmp++;
            if ({HI_out, LO_out} !== exp[i]) begin
                n_err++;
                $display("FAIL directed_product[%0d]: got %h_%h, want %h", i, HI_out, LO_out, exp[i]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat = 0;
        int busy_n = 0;
        int extra = 0;
        @(negedge clk);
        A_in = 32'd5; B_in = 32'd6; MultCtrl = 1'b1;
        @(negedge clk);
        MultCtrl = 1'b0;
        while (MultDone !== 1'b1 && lat < 100) begin
            if (MultBusy === 1'b1) busy_n++;
            if (lat == 10) begin
                A_in = 32'd9; B_in = 32'd9; MultCtrl = 1'b1;
            end else begin
                MultCtrl = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        MultCtrl = 1'b0;
        n_cmp++;
        if (lat != 33) begin
            n_err++;
            $display("FAIL ignore_latency: got %0d, want 33", lat);
        end
        n_cmp++;
        if (busy_n != 33) begin
            n_err++;
            $display("FAIL ignore_busy_cycles: got %0d, want 33", busy_n);
        end
        n_cmp++;
        if ({HI_out, LO_out} !== 64'd30) begin
            n_err++;
            $display("FAIL ignore_product: got %h_%h, want 0000001e", HI_out, LO_out);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MultDone === 1'b1 || MultBusy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL ignore_no_second_op: got %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_midop;
        int lat, busy_n, extra;
        bit to;
        run_op(32'hFFFFFFFF, 32'd2, lat, busy_n, to);
        n_cmp++;
        if (to || {HI_out, LO_out} !== 64'hFFFFFFFF_FFFFFFFE) begin
            n_err++;
            $display("FAIL pre_reset_product: got %h_%h, want ffffffff_fffffffe", HI_out, LO_out);
        end
        A_in = 32'd5; B_in = 32'd6; MultCtrl = 1'b1;
        @(negedge clk);
        MultCtrl = 1'b0;
        repeat (15) @(negedge clk);
        n_cmp++;
        if (MultBusy !== 1'b1) begin
            n_err++;
            $display("FAIL midop_busy: got %b, want 1", MultBusy);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({HI_out, LO_out, MultBusy, MultDone} !== 66'd0) begin
            n_err++;
            $display("FAIL async_reset_clear: got HI=%h LO=%h busy=%b done=%b, want all 0",
                     HI_out, LO_out, MultBusy, MultDone);
        end
        @(negedge clk);
        reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MultDone === 1'b1 || MultBusy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int lat, busy_n;
        bit to;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [63:0] first;
        a1 = $urandom; b1 = $urandom;
        first = ref_mul(a1, b1);
        run_op(a1, b1, lat, busy_n, to);
        n_cmp++;
        if (to || {HI_out, LO_out} !== first) begin
            n_err++;
            $display("FAIL b2b_first: got %h_%h, want %h", HI_out, LO_out, first);
        end
        // New start issued during the MultDone cycle.
        A_in = 32'hFFFFFFFF; B_in = 32'hFFFFFFFF; MultCtrl = 1'b1;
        @(negedge clk);
        MultCtrl = 1'b0;
        n_cmp++;
        if ({HI_out, LO_out} !== first || MultBusy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_hold: got %h_%h busy=%b, want %h busy=1", HI_out, LO_out, MultBusy, first);
        end
        wait_done(lat, busy_n, to);
        n_cmp++;
        if (to || lat != 33 || {HI_out, LO_out} !== 64'd1) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d %h_%h, want lat=33 0_1", lat, HI_out, LO_out);
        end
        // MultCtrl held high: restarts on every return to idle.
        A_in = 32'd3; B_in = 32'hFFFFFFFB; MultCtrl = 1'b1;
        @(negedge clk);
        wait_done(lat, busy_n, to);
        n_cmp++;
        if (to || lat != 33 || {HI_out, LO_out} !== 64'hFFFFFFFF_FFFFFFF1) begin
            n_err++;
            $display("FAIL held_first: got lat=%0d %h_%h, want lat=33 ffffffff_fffffff1", lat, HI_out, LO_out);
        end
        A_in = 32'd2; B_in = 32'd2;
        @(negedge clk);
        wait_done(lat, busy_n, to);
        MultCtrl = 1'b0;
        n_cmp++;
        if (to || lat != 33 || {HI_out, LO_out} !== 64'd4) begin
            n_err++;
            $display("FAIL held_second: got lat=%0d %h_%h, want lat=33 0_4", lat, HI_out, LO_out);
        end
    endtask

    task automatic test_random;
        logic [31:0] corners [5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int lat, busy_n;
        bit to;
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            exp = ref_mul(a, b);
            run_op(a, b, lat, busy_n, to);
            n_cmp++;
            if (to || lat != 33 || busy_n != 33) begin
                n_err++;
                $display("FAIL random_timing[%0d]: got lat=%0d busy=%0d, want 33/33", i, lat, busy_n);
            end
            n_cmp++;
            if ({HI_out, LO_out} !== exp) begin
                n_err++;
                $display("FAIL random_product[%0d]: %h*%h got %h_%h, want %h", i, a, b, HI_out, LO_out, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
